// File: rtl/thermo_disp_pkg.sv
// thermo_disp_pkg: seven-segment glyphs, converter states and sizing helpers for thermo_count_display
package thermo_disp_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGITS [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
  typedef enum logic [1:0] {B_IDLE, B_SHIFT, B_DONE} b2b_state_e;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    return d < 4'd10 ? SEG_DIGITS[d] : SEG_BLANK;
  endfunction
  function automatic int width_of(input int n);
    int d, v;
    d = 1;
    v = n;
    while (v >= 10) begin
      v = v / 10;
      d = d + 1;
    end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per SHIFT cycle
module bin2bcd_seq
  import thermo_disp_pkg::*;
#(
  parameter int W = 5,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  b2b_state_e state, state_nx;
  logic [4*N_DIGITS-1:0] acc, adj;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B_IDLE;
      acc <= '0;
      sh <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == B_IDLE && start) begin
        acc <= '0;
        sh <= bin;
        cnt <= '0;
      end else if (state == B_SHIFT) begin
        acc <= (adj << 1) | (4*N_DIGITS)'(sh[W-1]);
        sh <= sh << 1;
        cnt <= cnt + CW'(1);
      end
    end
  end
  always_comb begin
    adj = acc;
    for (int i = 0; i < N_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] > 4'd4 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    state_nx = state == B_IDLE ? (start ? B_SHIFT : B_IDLE) :
               state == B_SHIFT ? (cnt == CW'(W-1) ? B_DONE : B_SHIFT) : B_IDLE;
    busy = state != B_IDLE;
    done = state == B_DONE;
    bcd = acc;
  end
endmodule

// File: rtl/thermo_count_display.sv
// thermo_count_display: debounced switch popcount with thermometer check, shown on a multiplexed 7-seg display
module thermo_count_display
  import thermo_disp_pkg::*;
#(
  parameter int N_SW = 16,
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit STRICT = 1'b1,
  localparam int W = $clog2(N_SW + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SW-1:0]     sw,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an,
  output logic [W-1:0]        count,
  output logic                valid
);
  localparam int SB = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  if (N_SW < 1 || N_SW > 64 || N_DIGITS < width_of(N_SW) || SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("thermo_count_display: illegal parameter combination");
  end
  logic [N_SW-1:0] s1, s2, cand, deb;
  logic [SB-1:0] stab, stab_nx;
  logic hit, acc_p, go, pend, busy, done, err, any, dp_nx;
  logic [W-1:0] pc;
  logic [N_SW:0] mask;
  logic [4*N_DIGITS-1:0] bcd, digs;
  logic [N_DIGITS-1:0] show;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [3:0] cur;
  logic [6:0] seg_nx;
  bin2bcd_seq #(.W(W), .N_DIGITS(N_DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(go | pend), .bin(count), .busy(busy), .done(done), .bcd(bcd)
  );
  always_comb begin
    stab_nx = s2 != cand ? SB'(1) : stab < SB'(DEBOUNCE_CYCLES) ? stab + SB'(1) : stab;
    hit = (s2 != cand || stab != SB'(DEBOUNCE_CYCLES)) && stab_nx == SB'(DEBOUNCE_CYCLES);
    pc = '0;
    for (int i = 0; i < N_SW; i++) pc = pc + W'(deb[i]);
    mask = ((N_SW+1)'(1) << pc) - (N_SW+1)'(1);
    any = 1'b0;
    show = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      any = any | (digs[4*i +: 4] != 4'd0);
      show[i] = any | (i == 0);
    end
    cur = digs[4*idx +: 4];
    seg_nx = err ? (idx == '0 ? SEG_E : SEG_BLANK) : show[idx] ? bcd_to_seg(cur) : SEG_BLANK;
    dp_nx = !(err && idx == '0);
  end
  // a completed conversion is dropped when a newer count is already queued, so stale values never reach the digits
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      deb <= '0;
      stab <= SB'(DEBOUNCE_CYCLES);
      acc_p <= 1'b0;
      go <= 1'b0;
      pend <= 1'b0;
      count <= '0;
      valid <= 1'b1;
      digs <= '0;
      err <= 1'b0;
      pre <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      an <= '1;
    end else begin
      s1 <= sw;
      s2 <= s1;
      cand <= s2;
      stab <= stab_nx;
      if (hit) deb <= s2;
      acc_p <= hit && s2 != deb;
      go <= acc_p;
      if (acc_p) begin
        count <= pc;
        valid <= {1'b0, deb} == mask;
      end
      pend <= busy && (pend || go);
      if (done && !pend && !go) begin
        digs <= bcd;
        err <= STRICT && !valid;
      end
      pre <= pre == PW'(SCAN_DIV - 1) ? '0 : pre + PW'(1);
      if (pre == PW'(SCAN_DIV - 1)) begin
        idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + IW'(1);
        an <= ~(N_DIGITS'(1) << idx);
        seg <= seg_nx;
        dp <= dp_nx;
      end
    end
  end
endmodule
